// File: rtl/pbus_sync_iface.sv
// PBus-to-synchronous bridge: latches address/data, holds RD/WR for a set number of cycles, four-phase Ready handshake.
// Optional feature macro PBUS_SYNC_EN: two-flop synchronizers on the host strobes.

module pbus_sync_iface #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              PBusResetN,
  input  logic              PBusRDN,
  input  logic              PBusWRN,
  input  logic [ADDR_W-1:0] PBusAddr,
  input  logic [DATA_W-1:0] PBusDataIn,
  output logic [DATA_W-1:0] PBusDataOut,
  output logic              PBusDataOE,
  output logic              PBusReadyN,
  output logic              Reset,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] WData,
  input  logic [DATA_W-1:0] RData,
  output logic              RD,
  output logic              WR
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RDACT = 2'd1,
    WRACT = 2'd2,
    ACK   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                oe_q, oe_d;
  logic                rdy_n_q, rdy_n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                rdn, wrn;

`ifdef PBUS_SYNC_EN
  logic [1:0] rdn_sync_q, wrn_sync_q;

  // Strobes idle high, so the synchronizers reset to 1
  always_ff @(posedge Clk or negedge PBusResetN) begin
    if (!PBusResetN) begin
      rdn_sync_q <= 2'b11;
      wrn_sync_q <= 2'b11;
    end else begin
      rdn_sync_q <= {rdn_sync_q[0], PBusRDN};
      wrn_sync_q <= {wrn_sync_q[0], PBusWRN};
    end
  end

  assign rdn = rdn_sync_q[1];
  assign wrn = wrn_sync_q[1];
`else
  assign rdn = PBusRDN;
  assign wrn = PBusWRN;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    oe_d    = oe_q;
    rdy_n_d = rdy_n_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;

    case (state_q)
      IDLE: begin
        // Read has priority; a simultaneous write is dropped
        if (!rdn) begin
          addr_d  = PBusAddr;
          rd_d    = 1'b1;
          cnt_d   = CNT_W'(RD_CYCLES - 1);
          state_d = RDACT;
        end else if (!wrn) begin
          addr_d  = PBusAddr;
          wdata_d = PBusDataIn;
          wr_d    = 1'b1;
          cnt_d   = CNT_W'(WR_CYCLES - 1);
          state_d = WRACT;
        end
      end
      RDACT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rd_d    = 1'b0;
          dout_d  = RData;
          oe_d    = 1'b1;
          rdy_n_d = 1'b0;
          state_d = ACK;
        end
      end
      WRACT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          wr_d    = 1'b0;
          rdy_n_d = 1'b0;
          state_d = ACK;
        end
      end
      ACK: begin
        // Hold Ready until the host has released both strobes
        if (rdn && wrn) begin
          rdy_n_d = 1'b1;
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge PBusResetN) begin
    if (!PBusResetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      oe_q    <= 1'b0;
      rdy_n_q <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
      rdy_n_q <= rdy_n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
    end
  end

  assign PBusDataOut = dout_q;
  assign PBusDataOE  = oe_q;
  assign PBusReadyN  = rdy_n_q;
  assign Addr        = addr_q;
  assign WData       = wdata_q;
  assign RD          = rd_q;
  assign WR          = wr_q;
  assign Reset       = ~PBusResetN;

endmodule

// File: tb/tb_pbus_sync_iface.sv
// Self-checking bench for pbus_sync_iface: four instances with different RD/WR cycle counts share one host bus.
module tb_pbus_sync_iface;

  localparam int NI = 4;
`ifdef PBUS_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  function automatic int unsigned rc_of(input int g);
    case (g)
      0:       return 2;
      1:       return 4;
      2:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic int unsigned wc_of(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      2:       return 16;
      default: return 2;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rdn = 1'b1;
  logic        wrn = 1'b1;
  logic [7:0]  addr = '0;
  logic [31:0] din = '0;
  logic [31:0] rdata = '0;
  logic        clr = 1'b0;

  logic [31:0] dout_o  [NI];
  logic        oe_o    [NI];
  logic        rdyn_o  [NI];
  logic        reset_o [NI];
  logic [7:0]  addr_o  [NI];
  logic [31:0] wdata_o [NI];
  logic        rd_o    [NI];
  logic        wr_o    [NI];

  int rdc [NI];
  int wrc [NI];
  int ackc[NI];
  logic prev_rdy [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned RC = rc_of(g);
    localparam int unsigned WC = wc_of(g);
    pbus_sync_iface #(
      .ADDR_W(8), .DATA_W(32), .RD_CYCLES(RC), .WR_CYCLES(WC)
    ) u_dut (
      .Clk(clk), .PBusResetN(rst_n), .PBusRDN(rdn), .PBusWRN(wrn),
      .PBusAddr(addr), .PBusDataIn(din), .PBusDataOut(dout_o[g]),
      .PBusDataOE(oe_o[g]), .PBusReadyN(rdyn_o[g]), .Reset(reset_o[g]),
      .Addr(addr_o[g]), .WData(wdata_o[g]), .RData(rdata),
      .RD(rd_o[g]), .WR(wr_o[g])
    );
  end

  // Counts RD/WR high cycles and ReadyN falling edges per instance
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (clr) begin
        rdc[g] = 0;
        wrc[g] = 0;
        ackc[g] = 0;
      end else begin
        if (rd_o[g]) rdc[g]++;
        if (wr_o[g]) wrc[g]++;
        if (prev_rdy[g] && !rdyn_o[g]) ackc[g]++;
      end
      prev_rdy[g] = rdyn_o[g];
    end
  end

  typedef struct {
    bit          do_rd;
    bit          do_wr;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] rdat;
    int          hold;
    bit          exp_rd;
    bit          exp_wr;
    logic [7:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit all_rdy(input logic val);
    for (int g = 0; g < NI; g++) if (rdyn_o[g] !== val) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit all_quiet();
    for (int g = 0; g < NI; g++)
      if (rdyn_o[g] !== 1'b1 || rd_o[g] !== 1'b0 || wr_o[g] !== 1'b0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_ack(input string tag);
    int n = 0;
    while (!all_rdy(1'b0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(all_rdy(1'b0)), 32'd1);
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    while (!all_quiet() && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(all_quiet()), 32'd1);
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic txn(input vec_t v);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    addr  = v.a;
    din   = v.wd;
    rdata = v.rdat;
    rdn   = ~v.do_rd;
    wrn   = ~v.do_wr;
    wait_ack("ack_timeout");
    for (int g = 0; g < NI; g++) begin
      chk("ack_oe", 32'(oe_o[g]), 32'(v.exp_rd));
      chk("ack_addr", 32'(addr_o[g]), 32'(v.exp_addr));
      if (v.exp_rd) chk("ack_dout", dout_o[g], v.exp_dout);
    end
    repeat (v.hold) @(negedge clk);
    rdn = 1'b1;
    wrn = 1'b1;
    wait_quiet("release_timeout");
    for (int g = 0; g < NI; g++) begin
      chk("rd_cycles", 32'(rdc[g]), v.exp_rd ? rc_of(g) : 32'd0);
      chk("wr_cycles", 32'(wrc[g]), v.exp_wr ? wc_of(g) : 32'd0);
      chk("ack_count", 32'(ackc[g]), 32'd1);
      chk("idle_oe", 32'(oe_o[g]), 32'd0);
      chk("hold_addr", 32'(addr_o[g]), 32'(v.exp_addr));
      chk("hold_wdata", wdata_o[g], v.exp_wdata);
    end
  endtask

  // Cycle-exact check of instance 0 (RD_CYCLES=2, WR_CYCLES=1)
  task automatic timed_seq(input bit is_rd, input logic [7:0] a, input logic [31:0] d);
    int b;
    b = is_rd ? 2 : 1;
    @(negedge clk);
    addr = a;
    if (is_rd) begin
      rdata = d;
      rdn = 1'b0;
    end else begin
      din = d;
      wrn = 1'b0;
    end
    for (int i = 0; i <= LAT + b + 1; i++) begin
      @(negedge clk);
      chk(is_rd ? "t_rd" : "t_wr", 32'(is_rd ? rd_o[0] : wr_o[0]), 32'(i >= LAT && i < LAT + b));
      chk("t_other", 32'(is_rd ? wr_o[0] : rd_o[0]), 32'd0);
      chk("t_rdyn", 32'(rdyn_o[0]), 32'(!(i >= LAT + b)));
      if (i == LAT + b) begin
        chk("t_addr", 32'(addr_o[0]), 32'(a));
        if (is_rd) begin
          chk("t_dout", dout_o[0], d);
          chk("t_oe", 32'(oe_o[0]), 32'd1);
        end else begin
          chk("t_wdata", wdata_o[0], d);
          chk("t_oe", 32'(oe_o[0]), 32'd0);
        end
      end
    end
    rdn = 1'b1;
    wrn = 1'b1;
    for (int j = 1; j <= LAT + 1; j++) begin
      @(negedge clk);
      chk("t_release", 32'(rdyn_o[0]), 32'(j >= LAT + 1));
    end
    wait_quiet("t_quiet");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t post;
    vecs[0] = '{1'b1, 1'b1, 8'h56, 32'h1111_1111, 32'hCAFE_F00D, 0,
                1'b1, 1'b0, 8'h56, 32'h0000_005A, 32'hCAFE_F00D};
    vecs[1] = '{1'b1, 1'b0, 8'h78, 32'h2222_2222, 32'h0BAD_F00D, 20,
                1'b1, 1'b0, 8'h78, 32'h0000_005A, 32'h0BAD_F00D};
    vecs[2] = '{1'b0, 1'b1, 8'hFF, 32'hFFFF_FFFF, 32'h0000_0000, 20,
                1'b0, 1'b1, 8'hFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 32'h3333_3333, 32'h0000_0001, 3,
                1'b1, 1'b0, 8'h00, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[4] = '{1'b0, 1'b1, 8'h81, 32'hA5A5_A5A5, 32'h0000_0000, 0,
                1'b0, 1'b1, 8'h81, 32'hA5A5_A5A5, 32'h0000_0000};
    vecs[5] = '{1'b1, 1'b0, 8'h81, 32'h4444_4444, 32'h8000_0000, 1,
                1'b1, 1'b0, 8'h81, 32'hA5A5_A5A5, 32'h8000_0000};
    post    = '{1'b1, 1'b0, 8'h9A, 32'h5555_5555, 32'h1357_9BDF, 2,
                1'b1, 1'b0, 8'h9A, 32'h0000_0000, 32'h1357_9BDF};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("rst_rdyn", 32'(rdyn_o[g]), 32'd1);
      chk("rst_oe", 32'(oe_o[g]), 32'd0);
      chk("rst_rd", 32'(rd_o[g]), 32'd0);
      chk("rst_wr", 32'(wr_o[g]), 32'd0);
      chk("rst_addr", 32'(addr_o[g]), 32'd0);
      chk("rst_wdata", wdata_o[g], 32'd0);
      chk("rst_dout", dout_o[g], 32'd0);
      chk("rst_reset", 32'(reset_o[g]), 32'd1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("run_reset", 32'(reset_o[0]), 32'd0);

    timed_seq(1'b1, 8'h12, 32'hDEAD_BEEF);
    timed_seq(1'b0, 8'h34, 32'h0000_005A);

    for (int i = 0; i < 6; i++) txn(vecs[i]);

    // Reset pulse while instance 1 (RD_CYCLES=4) is mid-read
    @(negedge clk);
    addr  = 8'h9A;
    rdata = 32'h1357_9BDF;
    rdn   = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    chk("pre_rst_rd", 32'(rd_o[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rd", 32'(rd_o[1]), 32'd0);
    chk("abort_rdyn", 32'(rdyn_o[1]), 32'd1);
    chk("abort_oe", 32'(oe_o[1]), 32'd0);
    chk("abort_addr", 32'(addr_o[1]), 32'd0);
    chk("abort_reset", 32'(reset_o[1]), 32'd1);
    rdn = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset", 32'(reset_o[1]), 32'd0);
    txn(post);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
